fu_rr_arbiter: RTL and testbench



---
 rtl/fu_rr_arbiter.sv | 117 +++++++++++
 tb/tb_fu_rr_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fu_rr_arbiter.sv
// fu_rr_arbiter: round-robin sequencer sharing one multi-cycle FU among NREQ requesters.
// Define FU_RR_ARBITER_TIMEOUT_EN to add a WAIT watchdog (TIMEOUT cycles, ERR pulse).
module fu_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int DW = 8,
  parameter int PW = 2
`ifdef FU_RR_ARBITER_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 64
`endif
) (
  input  logic             CLK,
  input  logic             RST_X,
  input  logic [NREQ-1:0]  REQ,
  input  logic [NREQ*DW-1:0] REQ_DATA,
  output logic [NREQ-1:0]  GNT,
  output logic             FU_START,
  output logic [DW-1:0]    FU_IN,
  input  logic             FU_DONE,
  input  logic [DW-1:0]    FU_OUT,
  output logic [NREQ-1:0]  RSP_VALID,
  output logic [DW-1:0]    RSP_DATA,
  output logic             BUSY,
  output logic             ERR
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t          r_state;
  logic [PW-1:0]   r_ptr, r_owner, w_sel;
  logic [NREQ-1:0] r_gnt, r_rsp_valid;
  logic            r_start, r_busy;
  logic [DW-1:0]   r_fu_in, r_rsp_data;
  // (p + i) mod NREQ without a divider; p < NREQ and i <= NREQ
  function automatic logic [PW-1:0] wrap(input logic [PW-1:0] p, input int i);
    logic [PW:0] s;
    s = {1'b0, p} + (PW+1)'(i);
    return s >= (PW+1)'(NREQ) ? PW'(s - (PW+1)'(NREQ)) : PW'(s);
  endfunction
  // scan from the farthest offset down so the nearest set bit from r_ptr wins
  always_comb begin
    w_sel = r_ptr;
    for (int i = NREQ - 1; i >= 0; i--)
      if (REQ[wrap(r_ptr, i)]) w_sel = wrap(r_ptr, i);
  end
`ifdef FU_RR_ARBITER_TIMEOUT_EN
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] r_cnt;
  logic          r_err;
  assign ERR = r_err;
`else
  assign ERR = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (!RST_X) begin
      r_state     <= IDLE;
      r_ptr       <= '0;
      r_owner     <= '0;
      r_gnt       <= '0;
      r_start     <= 1'b0;
      r_fu_in     <= '0;
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
`ifdef FU_RR_ARBITER_TIMEOUT_EN
      r_cnt       <= '0;
      r_err       <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (|REQ) begin
          r_owner <= w_sel;
          r_fu_in <= REQ_DATA[w_sel*DW +: DW];
          r_ptr   <= wrap(w_sel, 1);
          r_gnt   <= NREQ'(1) << w_sel;
          r_start <= 1'b1;
          r_busy  <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: begin
          r_gnt   <= '0;
          r_start <= 1'b0;
          r_state <= WAIT;
`ifdef FU_RR_ARBITER_TIMEOUT_EN
          r_cnt   <= '0;
`endif
        end
        WAIT: if (FU_DONE) begin
          r_rsp_data  <= FU_OUT;
          r_rsp_valid <= NREQ'(1) << r_owner;
          r_state     <= RESP;
        end
`ifdef FU_RR_ARBITER_TIMEOUT_EN
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_rsp_data  <= '1;
          r_rsp_valid <= NREQ'(1) << r_owner;
          r_err       <= 1'b1;
          r_state     <= RESP;
        end else r_cnt <= r_cnt + 1'b1;
`endif
        RESP: begin
          r_rsp_valid <= '0;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
`ifdef FU_RR_ARBITER_TIMEOUT_EN
          r_err       <= 1'b0;
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end
  assign GNT       = r_gnt;
  assign FU_START  = r_start;
  assign FU_IN     = r_fu_in;
  assign RSP_VALID = r_rsp_valid;
  assign RSP_DATA  = r_rsp_data;
  assign BUSY      = r_busy;
endmodule

// File: tb/tb_fu_rr_arbiter.sv
// tb_fu_rr_arbiter: directed bench for fu_rr_arbiter (NREQ=4, DW=8; TIMEOUT=8 when FU_RR_ARBITER_TIMEOUT_EN).
module tb_fu_rr_arbiter;
  logic        CLK = 1'b0;
  logic        RST_X = 1'b0;
  logic [3:0]  REQ = '0;
  logic [31:0] REQ_DATA = '0;
  logic [3:0]  GNT, RSP_VALID;
  logic        FU_START, FU_DONE = 1'b0, BUSY, ERR;
  logic [7:0]  FU_IN, FU_OUT = '0, RSP_DATA;
  int n_chk = 0, n_pass = 0;

  fu_rr_arbiter #(
    .NREQ(4), .DW(8), .PW(2)
`ifdef FU_RR_ARBITER_TIMEOUT_EN
    , .TIMEOUT(8)
`endif
  ) dut (
    .CLK(CLK), .RST_X(RST_X), .REQ(REQ), .REQ_DATA(REQ_DATA), .GNT(GNT),
    .FU_START(FU_START), .FU_IN(FU_IN), .FU_DONE(FU_DONE), .FU_OUT(FU_OUT),
    .RSP_VALID(RSP_VALID), .RSP_DATA(RSP_DATA), .BUSY(BUSY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  // Called just after the arbitration edge; runs one op to completion, ends in IDLE.
  task automatic serve(input int k, input logic [7:0] opnd, input logic [7:0] res, input int lat);
    chk("gnt", 32'(GNT), 32'd1 << k);
    chk("fu_start", 32'(FU_START), 1);
    chk("fu_in", 32'(FU_IN), 32'(opnd));
    chk("busy_issue", 32'(BUSY), 1);
    tick;
    chk("gnt_drop", 32'(GNT), 0);
    chk("start_drop", 32'(FU_START), 0);
    for (int j = 1; j < lat; j++) tick;
    FU_DONE = 1'b1;
    FU_OUT = res;
    tick;
    FU_DONE = 1'b0;
    chk("rsp_valid", 32'(RSP_VALID), 32'd1 << k);
    chk("rsp_data", 32'(RSP_DATA), 32'(res));
    chk("fu_in_hold", 32'(FU_IN), 32'(opnd));
    chk("err_normal", 32'(ERR), 0);
    tick;
    chk("rsp_drop", 32'(RSP_VALID), 0);
    chk("rsp_data_hold", 32'(RSP_DATA), 32'(res));
    chk("busy_idle", 32'(BUSY), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    REQ = 4'hF;
    REQ_DATA = 32'h44332211;
    repeat (3) tick;
    chk("rst_gnt", 32'(GNT), 0);
    chk("rst_start", 32'(FU_START), 0);
    chk("rst_fu_in", 32'(FU_IN), 0);
    chk("rst_rsp_valid", 32'(RSP_VALID), 0);
    chk("rst_rsp_data", 32'(RSP_DATA), 0);
    chk("rst_busy", 32'(BUSY), 0);
    chk("rst_err", 32'(ERR), 0);
    RST_X = 1'b1;
    // all requesting: grants rotate 0,1,2,3,0,1,2,3
    for (int i = 0; i < 8; i++) begin
      tick;
      serve(i % 4, 8'(8'h11 * (i % 4 + 1)), 8'(8'hC0 + i), 1 + i % 3);
    end
    REQ = 4'b0001;
    tick;
    serve(0, 8'h11, 8'h01, 2);
    REQ = 4'b1001;
    tick;
    serve(3, 8'h44, 8'h02, 1);
    // single request from requester 2
    REQ = 4'b0100;
    REQ_DATA = 32'h445A2211;
    tick;
    serve(2, 8'h5A, 8'hA5, 3);
    REQ = 4'b0000;
    // spurious FU_DONE in IDLE
    FU_DONE = 1'b1;
    tick;
    FU_DONE = 1'b0;
    chk("spur_idle_rsp", 32'(RSP_VALID), 0);
    chk("spur_idle_busy", 32'(BUSY), 0);
    chk("spur_idle_gnt", 32'(GNT), 0);
    // ptr=3: REQ=0010 grants 1; FU_DONE during ISSUE is ignored
    REQ = 4'b0010;
    tick;
    REQ = 4'b0000;
    chk("spur_iss_gnt", 32'(GNT), 32'b0010);
    FU_DONE = 1'b1;
    FU_OUT = 8'hEE;
    tick;
    FU_DONE = 1'b0;
    chk("spur_iss_rsp", 32'(RSP_VALID), 0);
    chk("spur_iss_busy", 32'(BUSY), 1);
    tick;
    chk("spur_wait_rsp", 32'(RSP_VALID), 0);
    FU_DONE = 1'b1;
    FU_OUT = 8'h3C;
    tick;
    FU_DONE = 1'b0;
    chk("post_spur_rsp", 32'(RSP_VALID), 32'b0010);
    chk("post_spur_data", 32'(RSP_DATA), 32'h3C);
    tick;
    chk("post_spur_busy", 32'(BUSY), 0);
    // withdrawn request is never granted and leaves ptr=2
    REQ = 4'b1000;
    #2;
    REQ = 4'b0000;
    tick;
    chk("withdraw_gnt", 32'(GNT), 0);
    chk("withdraw_busy", 32'(BUSY), 0);
    REQ = 4'hF;
    tick;
    serve(2, 8'h5A, 8'h55, 1);
    // reset during WAIT discards the op and the late FU_DONE
    REQ = 4'b0001;
    tick;
    REQ = 4'b0000;
    chk("mid_gnt", 32'(GNT), 32'b0001);
    tick;
    tick;
    RST_X = 1'b0;
    tick;
    chk("mid_rst_busy", 32'(BUSY), 0);
    chk("mid_rst_fu_in", 32'(FU_IN), 0);
    RST_X = 1'b1;
    FU_DONE = 1'b1;
    FU_OUT = 8'h77;
    tick;
    FU_DONE = 1'b0;
    chk("mid_late_rsp", 32'(RSP_VALID), 0);
    chk("mid_late_data", 32'(RSP_DATA), 0);
    chk("mid_late_busy", 32'(BUSY), 0);
    REQ = 4'hF;
    tick;
    serve(0, 8'h11, 8'h66, 2);
    // FU never completes: ptr=1, REQ=0010 grants 1
    REQ = 4'b0010;
    tick;
    REQ = 4'b0000;
    chk("to_gnt", 32'(GNT), 32'b0010);
    tick;
`ifdef FU_RR_ARBITER_TIMEOUT_EN
    repeat (7) tick;
    chk("to_early_rsp", 32'(RSP_VALID), 0);
    chk("to_early_err", 32'(ERR), 0);
    tick;
    chk("to_rsp", 32'(RSP_VALID), 32'b0010);
    chk("to_data", 32'(RSP_DATA), 32'hFF);
    chk("to_err", 32'(ERR), 1);
    tick;
    chk("to_err_drop", 32'(ERR), 0);
    chk("to_busy_drop", 32'(BUSY), 0);
    FU_DONE = 1'b1;
    tick;
    FU_DONE = 1'b0;
    chk("to_late_rsp", 32'(RSP_VALID), 0);
    chk("to_late_busy", 32'(BUSY), 0);
    // FU_DONE on the timeout edge wins
    REQ = 4'b0100;
    tick;
    REQ = 4'b0000;
    chk("tie_gnt", 32'(GNT), 32'b0100);
    tick;
    repeat (7) tick;
    FU_DONE = 1'b1;
    FU_OUT = 8'h3C;
    tick;
    FU_DONE = 1'b0;
    chk("tie_rsp", 32'(RSP_VALID), 32'b0100);
    chk("tie_data", 32'(RSP_DATA), 32'h3C);
    chk("tie_err", 32'(ERR), 0);
    tick;
`else
    repeat (20) tick;
    chk("nto_busy", 32'(BUSY), 1);
    chk("nto_err", 32'(ERR), 0);
    chk("nto_rsp", 32'(RSP_VALID), 0);
    FU_DONE = 1'b1;
    FU_OUT = 8'h3C;
    tick;
    FU_DONE = 1'b0;
    chk("nto_done_rsp", 32'(RSP_VALID), 32'b0010);
    chk("nto_done_data", 32'(RSP_DATA), 32'h3C);
    tick;
`endif
    chk("end_busy", 32'(BUSY), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
